// File: rtl/seg_reader_if.sv
// seg_reader_if: bundles the multiplexed 7-segment bus, the frame handshake
// and the frame outputs of seg_reader. The slave side is the reader itself.
// The master side is the display/consumer environment that drives it.
interface seg_reader_if #(
  parameter int DIGITS = 4
);
  logic [7:0]          SEG;      // active-low segments, bit7 = DP, bits6:0 = g..a
  logic [DIGITS-1:0]   DIG_SEL;  // active-low digit enables
  logic                READY;    // consumer accepts frame
  logic [4*DIGITS-1:0] BCD;      // decoded frame, digit i in BCD[4i+3:4i]
  logic [DIGITS-1:0]   DP;       // decimal point per digit, 1 = lit
  logic [DIGITS-1:0]   ERR;      // 1 = digit pattern is not a 0-9 glyph
  logic                VALID;    // frame available
  logic                OVERRUN;  // sticky: a completed frame was dropped

  modport master (
    output SEG, DIG_SEL, READY,
    input  BCD, DP, ERR, VALID, OVERRUN
  );

  modport slave (
    input  SEG, DIG_SEL, READY,
    output BCD, DP, ERR, VALID, OVERRUN
  );
endinterface

// File: rtl/seg_reader.sv
// seg_reader: watches a multiplexed, active-low 7-segment display bus, decodes
// every scanned digit back to BCD once it has been stable long enough, and
// hands out one complete frame per full scan over a VALID/READY handshake.
//
// Optional build macro SEG_READER_SYNC_EN: inserts a two-flop synchronizer
// (reset to all-ones, i.e. inactive) on SEG and DIG_SEL for displays that are
// not clocked by CLK. This adds two cycles to capture and VALID latency.
module seg_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4   // identical samples needed to capture, >= 2
) (
  input logic        CLK,
  input logic        RST,
  seg_reader_if.slave bus
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int SAMP_W = 8 + DIGITS;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    SCAN,   // collecting digits, no frame on offer
    HOLD    // frame on offer, outputs frozen until accepted
  } state_e;

  // Raw glyph (active-low g..a) to {err, nibble}; anything else is an error.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h40:   res = 5'h00;
      7'h79:   res = 5'h01;
      7'h24:   res = 5'h02;
      7'h30:   res = 5'h03;
      7'h19:   res = 5'h04;
      7'h12:   res = 5'h05;
      7'h02:   res = 5'h06;
      7'h78:   res = 5'h07;
      7'h00:   res = 5'h08;
      7'h10:   res = 5'h09;
      default: res = {1'b1, 4'hF};
    endcase
    return res;
  endfunction

  // Bus samples as seen by the stability logic (direct or synchronized).
  logic [7:0]          seg_smp;
  logic [DIGITS-1:0]   sel_smp;

  // Stability tracking.
  logic [SAMP_W-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sel_ok;
  logic                capture;
  logic [DIGITS-1:0]   cap_mask;
  logic [4:0]          dec;

  // Per-digit capture slots and their "captured this frame" flags.
  logic [4*DIGITS-1:0] slot_bcd_q, slot_bcd_d;
  logic [DIGITS-1:0]   slot_dp_q, slot_dp_d;
  logic [DIGITS-1:0]   slot_err_q, slot_err_d;
  logic [DIGITS-1:0]   flags_q, flags_d;
  logic                frame_done;

  // Frame handshake and presented outputs.
  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                overrun_q, overrun_d;
  logic                load;

  // Stability counter: restart on any change, drop to zero when no single
  // digit is selected, and fire a capture exactly once per stable hold.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave one
    // unassigned, which would otherwise infer a latch.
    prev_d   = {seg_smp, sel_smp};
    cnt_d    = '0;
    capture  = 1'b0;
    cap_mask = '0;
    sel_ok   = ($countones(~sel_smp) == 1);

    if (!sel_ok) begin
      cnt_d = '0;
    end else if (prev_d != prev_q) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_FULL) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // Only the transition into the saturated value captures; longer holds
    // keep the counter parked at CNT_FULL and stay silent.
    capture  = sel_ok && (cnt_d == CNT_FULL) && (cnt_q != CNT_FULL);
    cap_mask = capture ? ~sel_smp : '0;
  end

  assign dec = decode(seg_smp[6:0]);

  // Write the decoded digit into the active slot; a repeat capture of the
  // same slot within a frame simply overwrites it.
  always_comb begin
    slot_bcd_d = slot_bcd_q;
    slot_dp_d  = slot_dp_q;
    slot_err_d = slot_err_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cap_mask[i]) begin
        slot_bcd_d[4*i +: 4] = dec[3:0];
        slot_dp_d[i]         = ~seg_smp[7];
        slot_err_d[i]        = dec[4];
      end
    end
  end

  // A frame is complete once every flag is set; the flags clear on the next
  // clock while any capture arriving on that same clock starts the next frame.
  always_comb begin
    frame_done = &flags_q;
    flags_d    = (frame_done ? '0 : flags_q) | cap_mask;
  end

  // Frame handshake: offer a complete frame, keep it frozen until accepted,
  // swap in a new frame on a same-cycle handshake, otherwise drop and flag.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      SCAN: begin
        if (frame_done) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (frame_done) begin
          if (bus.READY) begin
            load = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (bus.READY) begin
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase

    bcd_d = load ? slot_bcd_q : bcd_q;
    dp_d  = load ? slot_dp_q  : dp_q;
    err_d = load ? slot_err_q : err_q;
  end

  // Capture-path registers: previous sample, counter, slots and flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q     <= '0;
      cnt_q      <= '0;
      // NOTE: the slot storage is cleared on reset as well, so a reset
      // mid-frame can never leak a stale digit into a later frame.
      slot_bcd_q <= '0;
      slot_dp_q  <= '0;
      slot_err_q <= '0;
      flags_q    <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      slot_bcd_q <= slot_bcd_d;
      slot_dp_q  <= slot_dp_d;
      slot_err_q <= slot_err_d;
      flags_q    <= flags_d;
    end
  end

  // Handshake state and the frame presented to the consumer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= SCAN;
      bcd_q     <= '0;
      dp_q      <= '0;
      err_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      dp_q      <= dp_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SEG_READER_SYNC_EN
  logic [7:0]        seg_meta_q, seg_sync_q;
  logic [DIGITS-1:0] sel_meta_q, sel_sync_q;

  // Two-flop synchronizer; all-ones reset reads as "display blanked".
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seg_meta_q <= '1;
      seg_sync_q <= '1;
      sel_meta_q <= '1;
      sel_sync_q <= '1;
    end else begin
      seg_meta_q <= bus.SEG;
      seg_sync_q <= seg_meta_q;
      sel_meta_q <= bus.DIG_SEL;
      sel_sync_q <= sel_meta_q;
    end
  end

  assign seg_smp = seg_sync_q;
  assign sel_smp = sel_sync_q;
`else
  assign seg_smp = bus.SEG;
  assign sel_smp = bus.DIG_SEL;
`endif

  assign bus.BCD     = bcd_q;
  assign bus.DP      = dp_q;
  assign bus.ERR     = err_q;
  assign bus.VALID   = (state_q == HOLD);
  assign bus.OVERRUN = overrun_q;

  // A frame on offer must stay frozen while the consumer stalls.
  a_hold_stable: assert property (@(posedge CLK) disable iff (RST)
    (bus.VALID && !bus.READY) |=> ($stable(bus.BCD) && $stable(bus.DP) && $stable(bus.ERR)));

  // At most one slot can be written per clock.
  a_one_capture: assert property (@(posedge CLK) disable iff (RST)
    $onehot0(cap_mask));

endmodule

// File: tb/tb_seg_reader.sv
// tb_seg_reader: drives the display bus as a sequence of "holds" (one bus value
// held for N cycles). A transaction-level model turns each hold into captures
// and frames; expected frames go into a queue that an independent monitor pops
// whenever the reader presents a new frame.
module tb_seg_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;
`ifdef SEG_READER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_reader_if #(.DIGITS(DIGITS)) bus ();

  seg_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  // Glyph table for digits 0..9, raw active-low g..a.
  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  frame_t      exp_q[$];
  frame_t      m_slots;
  logic [3:0]  m_flags;
  bit          m_pending;   // a frame is on offer and not yet accepted
  bit          m_overrun;
  bit          m_ready;
  logic [3:0]  last_sel;
  logic [7:0]  last_seg;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (glyph[i] == p) return i;
    return -1;
  endfunction

  // A hold of n cycles on one selected digit captures iff n >= STABLE.
  task automatic model_hold(input logic [3:0] sel, input logic [7:0] seg, input int n);
    int idx;
    int lows;
    int v;
    idx  = 0;
    lows = 0;
    for (int i = 0; i < DIGITS; i++) if (!sel[i]) begin idx = i; lows++; end
    if (lows != 1 || n < STABLE) return;
    v = lookup(seg[6:0]);
    m_slots.bcd[4*idx +: 4] = (v < 0) ? 4'hF : 4'(v);
    m_slots.dp[idx]         = ~seg[7];
    m_slots.err[idx]        = (v < 0);
    m_flags[idx]            = 1'b1;
    if (&m_flags) begin
      m_flags = '0;
      if (!m_pending) begin
        exp_q.push_back(m_slots);
        m_pending = !m_ready;
      end else begin
        m_overrun = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_slots   = '0;
    m_flags   = '0;
    m_pending = 1'b0;
    m_overrun = 1'b0;
  endtask

  // ---------------- stimulus helpers (entered at posedge+1) ----------------
  task automatic drive(input logic [3:0] sel, input logic [7:0] seg, input int n);
    bus.DIG_SEL = sel;
    bus.SEG     = seg;
    last_sel    = sel;
    last_seg    = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] sel, input logic [7:0] seg, input int n);
    model_hold(sel, seg, n);
    drive(sel, seg, n);
  endtask

  task automatic gap();
    drive(4'hF, 8'hFF, LAT + 3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input bit r);
    bus.READY = r;
    m_ready   = r;
    if (r) m_pending = 1'b0;
  endtask

  task automatic scan4(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3, input int n);
    hold(4'b1110, s0, n);
    hold(4'b1101, s1, n);
    hold(4'b1011, s2, n);
    hold(4'b0111, s3, n);
  endtask

  task automatic do_reset();
    check("queue_drained_before_reset", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    repeat (3) begin
      bus.SEG     = 8'($urandom);
      bus.DIG_SEL = 4'($urandom);
      bus.READY   = 1'($urandom);
      tick();
    end
    @(negedge clk);
    check("rst_bcd",     32'(bus.BCD),     32'h0);
    check("rst_dp",      32'(bus.DP),      32'h0);
    check("rst_err",     32'(bus.ERR),     32'h0);
    check("rst_valid",   32'(bus.VALID),   32'h0);
    check("rst_overrun", 32'(bus.OVERRUN), 32'h0);
    tick();
    model_reset();
    bus.DIG_SEL = 4'hF;
    bus.SEG     = 8'hFF;
    bus.READY   = m_ready;
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit     fresh;
    frame_t cur;
    fresh = 1'b1;
    cur   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fresh = 1'b1;
      end else begin
        if (bus.VALID && fresh) begin
          check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("frame_bcd", 32'(bus.BCD), 32'(cur.bcd));
            check("frame_dp",  32'(bus.DP),  32'(cur.dp));
            check("frame_err", 32'(bus.ERR), 32'(cur.err));
          end
          fresh = 1'b0;
        end else if (bus.VALID) begin
          check("hold_stable", 32'({bus.BCD, bus.DP, bus.ERR}), 32'({cur.bcd, cur.dp, cur.err}));
        end
        if (bus.VALID && bus.READY) fresh = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin : stim
    logic [3:0] sel;
    logic [7:0] seg;
    int         n;
    bus.SEG     = 8'hFF;
    bus.DIG_SEL = 4'hF;
    bus.READY   = 1'b0;
    last_sel    = 4'hF;
    last_seg    = 8'hFF;
    m_ready     = 1'b1;
    model_reset();
    tick();

    // Reset state.
    do_reset();
    set_ready(1'b1);

    // Full frame 4321 with latency check on the last digit.
    hold(4'b1110, 8'hF9, 6);
    hold(4'b1101, 8'hA4, 6);
    hold(4'b1011, 8'hB0, 6);
    model_hold(4'b0111, 8'h99, 6);
    drive(4'b0111, 8'h99, STABLE + LAT);
    @(negedge clk);
    check("valid_not_early", 32'(bus.VALID), 32'd0);
    drive(4'b0111, 8'h99, 1);
    @(negedge clk);
    check("valid_rise", 32'(bus.VALID), 32'd1);
    check("bcd_4321",   32'(bus.BCD),   32'h4321);
    drive(4'b0111, 8'h99, 1);
    @(negedge clk);
    check("valid_one_cycle", 32'(bus.VALID), 32'd0);
    tick();
    gap();

    // Glitch, blanking and overlap: no capture until a 4-cycle hold.
    hold(4'b1110, 8'hF9, 3);
    hold(4'b1111, 8'hF9, 2);
    hold(4'b1101, 8'hA4, 5);
    hold(4'b1011, 8'hB0, 5);
    hold(4'b0111, 8'h99, 5);
    hold(4'b1100, 8'hF9, 6);
    gap();
    @(negedge clk);
    check("glitch_no_valid", 32'(bus.VALID), 32'd0);
    tick();
    hold(4'b1110, 8'hF9, 4);
    gap();

    // Invalid glyph and decimal point.
    scan4(8'h40, 8'hA4, 8'hFF, 8'h99, 5);
    gap();

    // Backpressure: second frame dropped, first held.
    set_ready(1'b0);
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h99, 5);
    gap();
    scan4(8'h92, 8'h82, 8'hF8, 8'h80, 5);
    gap();
    @(negedge clk);
    check("bp_overrun", 32'(bus.OVERRUN), 32'd1);
    check("bp_hold",    32'(bus.BCD),     32'h4321);
    tick();
    set_ready(1'b1);
    tick();
    @(negedge clk);
    check("bp_release", 32'(bus.VALID), 32'd0);
    tick();
    do_reset();

    // New frame completes in the same cycle as the handshake.
    set_ready(1'b0);
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h99, 5);
    gap();
    hold(4'b1110, 8'h92, 5);
    hold(4'b1101, 8'h82, 5);
    hold(4'b1011, 8'hF8, 5);
    m_pending = 1'b0;
    model_hold(4'b0111, 8'h80, STABLE + 2);
    drive(4'b0111, 8'h80, STABLE + LAT);
    bus.READY = 1'b1;
    drive(4'b0111, 8'h80, 1);
    bus.READY = 1'b0;
    drive(4'b0111, 8'h80, 1);
    gap();
    @(negedge clk);
    check("same_cycle_valid",   32'(bus.VALID),   32'd1);
    check("same_cycle_bcd",     32'(bus.BCD),     32'h8765);
    check("same_cycle_overrun", 32'(bus.OVERRUN), 32'd0);
    tick();
    set_ready(1'b1);
    gap();

    // Reset mid-frame discards partial captures.
    hold(4'b1110, 8'hF9, 5);
    hold(4'b1101, 8'hA4, 5);
    do_reset();
    set_ready(1'b1);
    hold(4'b1011, 8'hB0, 5);
    hold(4'b0111, 8'h99, 5);
    gap();
    @(negedge clk);
    check("midreset_no_valid", 32'(bus.VALID), 32'd0);
    tick();
    hold(4'b1110, 8'hC0, 5);
    hold(4'b1101, 8'h90, 5);
    gap();

    // Randomized streams with random backpressure phases.
    for (int r = 0; r < 60; r++) begin
      set_ready($urandom_range(0, 3) != 0);
      gap();
      for (int h = 0; h < 7; h++) begin
        do begin
          if ($urandom_range(0, 9) < 7) begin
            sel = ~(4'b0001 << $urandom_range(0, 3));
            n   = int'($urandom_range(1, 7));
          end else begin
            sel = 4'($urandom);
            n   = int'($urandom_range(1, 4));
          end
          if ($urandom_range(0, 4) != 0)
            seg = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 9)]};
          else
            seg = 8'($urandom);
        end while ({seg, sel} == {last_seg, last_sel});
        hold(sel, seg, n);
      end
      gap();
      @(negedge clk);
      check("rand_overrun", 32'(bus.OVERRUN), 32'(m_overrun));
      tick();
    end

    set_ready(1'b1);
    gap();
    gap();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_reader.md
Name: seg_reader

Overview:
- Receive-side counterpart of the team's BCD-to-7-segment display driver.
- Monitors a multiplexed, active-low, multi-digit 7-segment bus (segment lines plus active-low digit selects) and decodes each scanned digit back to BCD.
- After every digit has been captured, presents one complete frame through a VALID/READY handshake.
- Used for display loopback self-test and for reading external 7-segment instruments.

Parameters:
DIGITS, 4, number of multiplexed digits (slots 0..DIGITS-1)
STABLE_CYCLES, 4, consecutive identical samples needed to capture a digit (>=2)

Ports:
CLK  in  1  clock
RST  in  1  reset
SEG  in  8  active-low segments: bit7 = DP; bits6:0 = g..a
DIG_SEL  in  DIGITS  active-low digit enables; exactly one low = digit active
READY  in  1  consumer accepts frame
BCD  out  4*DIGITS  decoded frame; digit i in BCD[4i+3:4i]
DP  out  DIGITS  decimal point per digit; 1 = lit (SEG[7]==0)
ERR  out  DIGITS  1 = pattern for that digit not a valid 0-9 glyph
VALID  out  1  frame available
OVERRUN  out  1  sticky: a completed frame was dropped

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (CLK, RST).
- Reset values: BCD=0, DP=0, ERR=0, VALID=0, OVERRUN=0. Slot registers, capture flags and stability counter cleared; FSM=SCAN. Reset mid-frame discards partial captures.
- Inputs are treated as synchronous to CLK unless SEG_READER_SYNC_EN is defined.
- Stability counter:
  - Compares {SEG, DIG_SEL} against the previous cycle's value.
  - If DIG_SEL is not exactly one-hot-low (blanking or overlap), the counter goes to 0 and nothing is captured.
  - If the value changed, the counter goes to 1; if unchanged, it increments, saturating at STABLE_CYCLES.
- Capture:
  - Occurs only on the cycle the counter becomes STABLE_CYCLES, i.e. the STABLE_CYCLES-th identical sample.
  - Writes the decoded nibble, DP and ERR into the active slot and sets that slot's flag.
  - A longer hold does not re-capture.
  - Re-capture of an already-flagged slot before frame completion overwrites it; latest wins.
- Decode on SEG[6:0], raw active-low, giving BCD:
  - 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9.
  - Any other pattern, including blank 0x7F: nibble=4'hF, ERR=1.
- Frame complete: all DIGITS flags set, evaluated after the capture write. On the following clock the flags clear; capture continues into the slots for the next frame.
- FSM:
  - SCAN: on frame complete, load BCD/DP/ERR from the slots, VALID=1, go to HOLD.
  - HOLD: BCD/DP/ERR are stable while VALID=1.
  - HOLD, VALID&READY with no new frame: VALID=0 next cycle, go to SCAN.
  - HOLD, new frame completes in the same cycle as VALID&READY: load the new frame, VALID stays 1, no overrun.
  - HOLD, new frame completes while READY=0: frame dropped, outputs unchanged, OVERRUN=1.
- OVERRUN is sticky until RST.
- Latency:
  - Capture occurs STABLE_CYCLES-1 cycles after the first sample of a stable digit.
  - VALID rises 1 cycle after the last capture.

Optional Feature:
- Macro: SEG_READER_SYNC_EN.
- Defined: a two-flop synchronizer on SEG and DIG_SEL, reset to all-ones (inactive), for asynchronous external displays. Adds 2 cycles of latency to capture and VALID; all other rules unchanged.
- Undefined: inputs are sampled directly with no added latency.

Test Plan:
- Reset: assert RST for 3 cycles with random inputs -> BCD=16'h0000, DP=0, ERR=0, VALID=0, OVERRUN=0.
- Full frame: DIG_SEL=4'b1110/SEG=8'hF9, then 4'b1101/8'hA4, 4'b1011/8'hB0, 4'b0111/8'h99, each for 6 cycles, READY=1 -> VALID=1 for one cycle; BCD=16'h4321, DP=0, ERR=0; VALID rises 1 cycle after the 4th sample of digit 3.
- Glitch/blanking: one digit held only 3 cycles, or DIG_SEL=4'b1111 or 4'b1100 -> no capture, VALID stays 0 until the digit is held for 4 or more cycles.
- Invalid/DP: digit0 SEG=8'h40, digit2 SEG=8'hFF, others valid -> DP[0]=1, BCD[3:0]=0, BCD[11:8]=4'hF, ERR=4'b0100.
- Backpressure: READY=0, scan two full frames (4321 then 8765) -> outputs hold 16'h4321, OVERRUN=1. Then READY=1 -> VALID=0 next cycle. Separately, frame completing in the same cycle as the handshake -> VALID stays 1, new BCD, OVERRUN=0.
- Reset mid-frame: capture digits 0-1, pulse RST, then scan only digits 2-3 -> VALID stays 0; a frame completes only after all 4 digits are rescanned.
